// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
// Module   : iterative_divider
// Brief    : Multi-cycle RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring
//            division over magnitudes with a final sign fix-up.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] operand1,
    input  logic [DATA_WIDTH-1:0] operand2,
    input  logic [REG_ADDR_W-1:0] desIn,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [REG_ADDR_W-1:0] desRegister,
    output logic                  writeEnable
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] c_minNeg  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_allOnes = {DATA_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0]      r_count;
    logic                  r_isRem;
    logic                  r_negQ;
    logic                  r_negR;
    logic [REG_ADDR_W-1:0] r_desLatch;
    logic [DATA_WIDTH-1:0] r_result;
    logic [REG_ADDR_W-1:0] r_desOut;

    // Acceptance-time decode
    logic                  w_accept;
    logic                  w_signed;
    logic                  w_divZero;
    logic                  w_overflow;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_absA;
    logic [DATA_WIDTH-1:0] w_absB;
    logic [DATA_WIDTH-1:0] w_specialResult;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_signed   = ~op[0];
    assign w_divZero  = (operand2 == '0);
    assign w_overflow = w_signed && (operand1 == c_minNeg) && (operand2 == c_allOnes);
    assign w_special  = w_divZero || w_overflow;
    assign w_absA     = (w_signed && operand1[DATA_WIDTH-1]) ? ('0 - operand1) : operand1;
    assign w_absB     = (w_signed && operand2[DATA_WIDTH-1]) ? ('0 - operand2) : operand2;
    assign w_specialResult = op[1] ? (w_divZero ? operand1  : '0)
                                   : (w_divZero ? c_allOnes : c_minNeg);

    // One restoring step: shift in the next dividend bit and try to subtract
    logic [DATA_WIDTH:0]   w_shifted;
    logic [DATA_WIDTH:0]   w_diff;
    logic                  w_qBit;
    logic [DATA_WIDTH-1:0] w_remNext;
    logic [DATA_WIDTH-1:0] w_quoNext;
    logic                  w_lastIter;
    logic [DATA_WIDTH-1:0] w_finalResult;

    assign w_shifted     = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_diff        = w_shifted - {1'b0, r_divisor};
    assign w_qBit        = ~w_diff[DATA_WIDTH];
    assign w_remNext     = w_qBit ? w_diff[DATA_WIDTH-1:0] : w_shifted[DATA_WIDTH-1:0];
    assign w_quoNext     = {r_quo[DATA_WIDTH-2:0], w_qBit};
    assign w_lastIter    = (r_count == CNT_W'(DATA_WIDTH-1));
    assign w_finalResult = r_isRem ? (r_negR ? ('0 - w_remNext) : w_remNext)
                                   : (r_negQ ? ('0 - w_quoNext) : w_quoNext);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = w_special ? DONE : CALC;
            CALC:    if (w_lastIter) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_quo      <= '0;
            r_rem      <= '0;
            r_divisor  <= '0;
            r_count    <= '0;
            r_isRem    <= 1'b0;
            r_negQ     <= 1'b0;
            r_negR     <= 1'b0;
            r_desLatch <= '0;
            r_result   <= '0;
            r_desOut   <= '0;
        end else if (w_accept) begin
            r_quo      <= w_absA;
            r_rem      <= '0;
            r_divisor  <= w_absB;
            r_count    <= '0;
            r_isRem    <= op[1];
            r_negQ     <= w_signed && (operand1[DATA_WIDTH-1] ^ operand2[DATA_WIDTH-1]);
            r_negR     <= w_signed && operand1[DATA_WIDTH-1];
            r_desLatch <= desIn;
            if (w_special) begin
                r_result <= w_specialResult;
                r_desOut <= desIn;
            end
        end else if (r_state == CALC) begin
            r_quo   <= w_quoNext;
            r_rem   <= w_remNext;
            r_count <= r_count + CNT_W'(1);
            // Outputs only change on completion so they hold between operations
            if (w_lastIter) begin
                r_result <= w_finalResult;
                r_desOut <= r_desLatch;
            end
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign writeEnable = done;
    assign result      = r_result;
    assign desRegister = r_desOut;

endmodule
`default_nettype wire

// File: tb/tb_iterative_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_iterative_divider
// Brief    : Directed vector bench for iterative_divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iterative_divider;

    localparam logic [1:0] c_div  = 2'b00;
    localparam logic [1:0] c_divu = 2'b01;
    localparam logic [1:0] c_rem  = 2'b10;
    localparam logic [1:0] c_remu = 2'b11;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic [4:0]  desIn = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  desRegister;
    logic        writeEnable;

    int total = 0;
    int bad   = 0;

    iterative_divider #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .start       (start),
        .op          (op),
        .operand1    (operand1),
        .operand2    (operand2),
        .desIn       (desIn),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .desRegister (desRegister),
        .writeEnable (writeEnable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  des;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic runOp(input vec_t v, input string name);
        int  cyc;
        bit  seen;
        op       = v.op;
        operand1 = v.a;
        operand2 = v.b;
        desIn    = v.des;
        start    = 1'b1;
        step();
        start    = 1'b0;
        operand1 = 32'hDEAD_BEEF;
        operand2 = 32'h1234_5678;
        check({name, " busyAfterAccept"}, 32'(busy), 32'd1);
        cyc  = 1;
        seen = 0;
        while (cyc < 100) begin
            if (done) begin
                seen = 1;
                break;
            end
            step();
            cyc++;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s timeout: no done within %0d cycles, want %0d", name, cyc, v.lat);
        end else begin
            check({name, " latency"}, 32'(cyc), 32'(v.lat));
            check({name, " result"}, result, v.exp);
            check({name, " desRegister"}, 32'(desRegister), 32'(v.des));
            check({name, " writeEnable"}, 32'(writeEnable), 32'd1);
            step();
            check({name, " donePulse"}, {30'd0, done, writeEnable}, 32'd0);
            check({name, " busyDrop"}, 32'(busy), 32'd0);
            check({name, " resultHold"}, result, v.exp);
        end
    endtask

    initial begin
        int pulses;
        int doneAt;
        logic [31:0] gotRes;
        logic [4:0]  gotDes;

        vecs[0]  = '{c_div,  32'd100,        32'd7,          5'd5,  32'd14,         33};
        vecs[1]  = '{c_rem,  32'd100,        32'd7,          5'd6,  32'd2,          33};
        vecs[2]  = '{c_div,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  33};
        vecs[3]  = '{c_rem,  32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  33};
        vecs[4]  = '{c_remu, 32'hFFFF_FFF9,  32'd2,          5'd9,  32'd1,          33};
        vecs[5]  = '{c_divu, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  1};
        vecs[6]  = '{c_remu, 32'd5,          32'd0,          5'd11, 32'd5,          1};
        vecs[7]  = '{c_div,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1};
        vecs[8]  = '{c_rem,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1};
        vecs[9]  = '{c_div,  32'd5,          32'd0,          5'd14, 32'hFFFF_FFFF,  1};
        vecs[10] = '{c_rem,  32'hFFFF_FFFB,  32'd0,          5'd15, 32'hFFFF_FFFB,  1};
        vecs[11] = '{c_divu, 32'h8000_0000,  32'hFFFF_FFFF,  5'd16, 32'd0,          33};
        vecs[12] = '{c_div,  32'd7,          32'hFFFF_FFFE,  5'd17, 32'hFFFF_FFFD,  33};
        vecs[13] = '{c_rem,  32'd7,          32'hFFFF_FFFE,  5'd0,  32'd1,          33};
        vecs[14] = '{c_rem,  32'hFFFF_FFF8,  32'hFFFF_FFFD,  5'd18, 32'hFFFF_FFFE,  33};
        vecs[15] = '{c_divu, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  33};

        // Reset state
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done/we", {30'd0, done, writeEnable}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset desRegister", 32'(desRegister), 32'd0);
        rstN = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            runOp(vecs[i], $sformatf("vec%0d", i));
        end

        // A start pulse while busy is ignored
        op = c_div; operand1 = 32'd1000; operand2 = 32'd10; desIn = 5'd3;
        start = 1'b1;
        pulses = 0; doneAt = 0; gotRes = '0; gotDes = '0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (done) begin
                pulses++;
                doneAt = k;
                gotRes = result;
                gotDes = desRegister;
            end
            if (k == 10) begin
                op = c_divu; operand1 = 32'd9; operand2 = 32'd0; desIn = 5'd7;
                start = 1'b1;
            end
            if (k == 11) start = 1'b0;
        end
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore doneAt", 32'(doneAt), 32'd33);
        check("ignore result", gotRes, 32'd100);
        check("ignore desRegister", 32'(gotDes), 32'd3);

        // start held through DONE: ignored there, accepted the cycle after
        op = c_divu; operand1 = 32'd9; operand2 = 32'd0; desIn = 5'd1;
        start = 1'b1;
        step();
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first result", result, 32'hFFFF_FFFF);
        operand1 = 32'd20; operand2 = 32'd4; desIn = 5'd2;
        step();
        check("b2b gap busy", {30'd0, busy, done}, 32'd0);
        step();
        start = 1'b0;
        check("b2b second accepted", 32'(busy), 32'd1);
        pulses = 0; doneAt = 0;
        for (int k = 2; k <= 40; k++) begin
            step();
            if (done && doneAt == 0) begin
                doneAt = k;
                gotRes = result;
                gotDes = desRegister;
            end
        end
        check("b2b second doneAt", 32'(doneAt), 32'd33);
        check("b2b second result", gotRes, 32'd5);
        check("b2b second desRegister", 32'(gotDes), 32'd2);

        // Asynchronous reset in the middle of an operation
        op = c_div; operand1 = 32'd100; operand2 = 32'd7; desIn = 5'd9;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 2; k <= 15; k++) step();
        rstN = 1'b0;
        #1;
        check("midReset busy", 32'(busy), 32'd0);
        check("midReset done/we", {30'd0, done, writeEnable}, 32'd0);
        check("midReset result", result, 32'd0);
        check("midReset desRegister", 32'(desRegister), 32'd0);
        step();
        step();
        rstN = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (writeEnable) pulses++;
        end
        check("midReset no write", 32'(pulses), 32'd0);
        runOp(vecs[0], "postReset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
